reg_writeback: RTL and testbench

//  Write-side front end of the 32x32 register file. Accepts results from the ALU and

---
 rtl/rv_wb_pkg.sv | 24 ++
 rtl/reg_writeback_wb_fifo.sv | 72 +++++++
 rtl/reg_writeback.sv | 112 +++++++++++
 tb/tb_reg_writeback.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared types for the register-file write-back front end.
// Entry layout, source ids and the destination one-hot helper.
package rv_wb_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  function automatic logic [31:0] rd_onehot(
    input logic [AW-1:0] rd
  );
    return 32'(1) << rd;
  endfunction

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// Sync FIFO of write-back entries with push/pop/flush and occupancy.
// Ports: push/push_entry in, pop/flush in, head/count/entries/valid out.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output wb_entry_t               head,
  output logic [CW-1:0]           count,
  output wb_entry_t [DEPTH-1:0]   entries,
  output logic [DEPTH-1:0]        valid
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_entry;
        wr_d        = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Slot i is live when its distance from the read pointer
  // (mod DEPTH) is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    assign valid[i] = {1'b0, PW'(i) - rd_q} < cnt_q;
  end

  assign head    = mem_q[rd_q];
  assign count   = cnt_q;
  assign entries = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// Write-side front end of the register file: arbitrates ALU/MEM results,
// buffers them, drains one per cycle and exports a pending-rd mask.
module reg_writeback
  import rv_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            mem_valid,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            mem_ready,
  input  logic            wb_hold,
  input  logic            flush,
  output logic            write_en,
  output logic [AW-1:0]   reg_write_des_addr,
  output logic [XLEN-1:0] write_reg_data,
  output logic [31:0]     pending_mask,
  output logic [CW-1:0]   wb_count
);

  wb_src_e               last_grant_q, last_grant_d;
  wb_entry_t             push_entry, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [CW-1:0]         count;
  logic                  pop, space, push;
  logic                  grant_alu, grant_mem;

  assign pop   = (count != '0) & ~wb_hold & ~flush;
  assign space = (count < CW'(DEPTH)) | pop;

  // Round-robin: on contention the source that did not win last time
  // gets the slot.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst && space && !flush) begin
      if (alu_valid && mem_valid) begin
        grant_alu = (last_grant_q == WB_SRC_MEM);
        grant_mem = (last_grant_q == WB_SRC_ALU);
      end else begin
        grant_alu = alu_valid;
        grant_mem = mem_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    unique case (1'b1)
      grant_alu: last_grant_d = WB_SRC_ALU;
      grant_mem: last_grant_d = WB_SRC_MEM;
      default:   last_grant_d = last_grant_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= WB_SRC_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // x0 writes are handshaken but never occupy a slot.
  always_comb begin
    push_entry.rd   = grant_mem ? mem_rd : alu_rd;
    push_entry.data = grant_mem ? mem_data : alu_data;
  end

  assign push = (grant_alu | grant_mem) & (push_entry.rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (count),
    .entries    (entries),
    .valid      (valid)
  );

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        pending_mask = pending_mask | rd_onehot(entries[i].rd);
      end
    end
  end

  // Idle port always targets x0 with zero data.
  assign write_en           = pop;
  assign reg_write_des_addr = pop ? head.rd : '0;
  assign write_reg_data     = pop ? head.data : '0;
  assign alu_ready          = grant_alu;
  assign mem_ready          = grant_mem;
  assign wb_count           = count;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table, directed
// corner sequences and randomized traffic against a queue model.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        av, mv, hold, fl;
  logic [4:0]  ar, mr;
  logic [31:0] ad, md;
  logic        alu_ready, mem_ready, write_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pending_mask;
  logic [2:0]  wb_count;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_valid          (av),
    .alu_rd             (ar),
    .alu_data           (ad),
    .alu_ready          (alu_ready),
    .mem_valid          (mv),
    .mem_rd             (mr),
    .mem_data           (md),
    .mem_ready          (mem_ready),
    .wb_hold            (hold),
    .flush              (fl),
    .write_en           (write_en),
    .reg_write_des_addr (addr),
    .write_reg_data     (wdata),
    .pending_mask       (pending_mask),
    .wb_count           (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_last_alu;

  logic        s_ar, s_mr, s_we;
  logic [4:0]  s_addr;
  logic [31:0] s_data, s_mask;
  logic [2:0]  s_cnt;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        hold;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_mask;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare outputs with the queue model just before the
  // rising edge, then advance the model with what the edge does.
  task automatic cycle();
    bit          pop, space, ga, gm;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_mask;
    ent_t        e;
    #4;
    pop   = (mq.size() != 0) && !hold && !fl;
    space = (mq.size() < DEPTH) || pop;
    ga = 0;
    gm = 0;
    if (space && !fl) begin
      if (av && mv) begin
        ga = !m_last_alu;
        gm = m_last_alu;
      end else begin
        ga = av;
        gm = mv;
      end
    end
    e_addr = pop ? mq[0].rd : 5'd0;
    e_data = pop ? mq[0].data : 32'd0;
    e_mask = 0;
    foreach (mq[i]) e_mask |= 32'd1 << mq[i].rd;
    chk("alu_ready", 32'(alu_ready), 32'(ga));
    chk("mem_ready", 32'(mem_ready), 32'(gm));
    chk("write_en", 32'(write_en), 32'(pop));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("data", wdata, e_data);
    chk("pending_mask", pending_mask, e_mask);
    chk("wb_count", 32'(wb_count), mq.size());
    s_ar = alu_ready; s_mr = mem_ready; s_we = write_en;
    s_addr = addr; s_data = wdata; s_mask = pending_mask;
    s_cnt = wb_count;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (ga) begin
        m_last_alu = 1;
        e.rd = ar; e.data = ad;
        if (ar != 0) mq.push_back(e);
      end
      if (gm) begin
        m_last_alu = 0;
        e.rd = mr; e.data = md;
        if (mr != 0) mq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    av = 0; ar = 0; ad = 0;
    mv = 0; mr = 0; md = 0;
    hold = 0; fl = 0;
  endtask

  initial begin
    logic [4:0] got[$];
    logic [4:0] ecom[8];
    int         ai, mi;
    bit         ap, mp;

    rst = 0;
    idle_in();
    av = 1; ar = 5'd3; ad = 32'h1;
    #1 rst = 1;
    #2;
    chk("rst_write_en", 32'(write_en), 0);
    chk("rst_mask", pending_mask, 0);
    chk("rst_count", 32'(wb_count), 0);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_addr", 32'(addr), 0);
    mq.delete();
    m_last_alu = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    idle_in();

    tv[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0,
               1, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 1, 5, 32'hDEADBEEF, 32'h20, 1};
    tv[2]  = '{0, 0, 0, 1, 0, 32'hFFFFFFFF, 0,
               0, 1, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{1, 1, 1, 1, 11, 11, 0,
               1, 0, 0, 0, 0, 0, 0};
    tv[5]  = '{1, 2, 2, 1, 11, 11, 0,
               0, 1, 1, 1, 1, 32'h2, 1};
    tv[6]  = '{1, 2, 2, 1, 12, 12, 0,
               1, 0, 1, 11, 11, 32'h800, 1};
    tv[7]  = '{1, 3, 3, 1, 12, 12, 0,
               0, 1, 1, 2, 2, 32'h4, 1};
    tv[8]  = '{1, 3, 3, 0, 0, 0, 1,
               1, 0, 0, 0, 0, 32'h1000, 1};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 1, 12, 12, 32'h1008, 2};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 1, 3, 3, 32'h8, 1};
    tv[11] = '{0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0};

    for (int i = 0; i < 12; i++) begin
      av = tv[i].av; ar = tv[i].ar; ad = tv[i].ad;
      mv = tv[i].mv; mr = tv[i].mr; md = tv[i].md;
      hold = tv[i].hold; fl = 0;
      cycle();
      chk($sformatf("tv%0d_ar", i), 32'(s_ar), 32'(tv[i].e_ar));
      chk($sformatf("tv%0d_mr", i), 32'(s_mr), 32'(tv[i].e_mr));
      chk($sformatf("tv%0d_we", i), 32'(s_we), 32'(tv[i].e_we));
      chk($sformatf("tv%0d_addr", i), 32'(s_addr), 32'(tv[i].e_addr));
      chk($sformatf("tv%0d_data", i), s_data, tv[i].e_data);
      chk($sformatf("tv%0d_mask", i), s_mask, tv[i].e_mask);
      chk($sformatf("tv%0d_cnt", i), 32'(s_cnt), 32'(tv[i].e_cnt));
    end
    idle_in();

    // Async reset with three entries buffered.
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      av = 1; ar = 5'(7 + i); ad = 32'(70 + i);
      cycle();
    end
    chk("pre_rst_cnt", 32'(wb_count), 3);
    av = 1; ar = 5'd10; hold = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_write_en", 32'(write_en), 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_count", 32'(wb_count), 0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 0);
    mq.delete();
    m_last_alu = 0;
    @(negedge clk);
    rst = 0;
    idle_in();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_no_write", 32'(s_we), 0);
    end

    // Contention: both sources streaming.
    ecom = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    ai = 0; mi = 0;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      av = (ai < 4); ar = 5'(1 + ai); ad = 32'(100 + ai);
      mv = (mi < 4); mr = 5'(11 + mi); md = 32'(200 + mi);
      cycle();
      if (av && mv) chk("one_ready", 32'(s_ar) + 32'(s_mr), 1);
      if (s_we) got.push_back(s_addr);
      if (s_ar) ai++;
      if (s_mr) mi++;
    end
    idle_in();
    chk("contention_commits", got.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("contention_order%0d", i),
          32'(i < got.size() ? got[i] : 5'h1f), 32'(ecom[i]));

    // Backpressure: five pushes into a four-deep buffer under hold.
    hold = 1;
    ai = 0;
    for (int c = 0; c < 5; c++) begin
      av = (ai < 5); ar = 5'(21 + ai); ad = 32'(300 + ai);
      cycle();
      if (s_ar) ai++;
    end
    chk("bp_accepted", ai, 4);
    chk("bp_count", 32'(s_cnt), 4);
    chk("bp_fifth_ready", 32'(s_ar), 0);
    got.delete();
    hold = 0;
    av = 1; ar = 5'd25; ad = 32'd304;
    cycle();
    chk("bp_full_pushpop_ready", 32'(s_ar), 1);
    chk("bp_full_pushpop_we", 32'(s_we), 1);
    chk("bp_full_pushpop_cnt", 32'(s_cnt), 4);
    if (s_we) got.push_back(s_addr);
    av = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (s_we) got.push_back(s_addr);
    end
    chk("bp_commits", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("bp_order%0d", i),
          32'(i < got.size() ? got[i] : 5'h1f), 21 + i);
    idle_in();

    // Flush with three entries and a waiting source.
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      av = 1; ar = 5'(7 + i); ad = 32'(90 + i);
      cycle();
    end
    hold = 0; fl = 1;
    av = 1; ar = 5'd17; ad = 32'h17;
    cycle();
    chk("flush_alu_ready", 32'(s_ar), 0);
    chk("flush_mem_ready", 32'(s_mr), 0);
    chk("flush_we", 32'(s_we), 0);
    fl = 0;
    cycle();
    chk("post_flush_cnt", 32'(s_cnt), 0);
    chk("post_flush_ready", 32'(s_ar), 1);
    chk("post_flush_we", 32'(s_we), 0);
    av = 0;
    cycle();
    chk("post_flush_commit_we", 32'(s_we), 1);
    chk("post_flush_commit_addr", 32'(s_addr), 17);
    idle_in();

    // Randomized traffic against the queue model.
    ap = 0; mp = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1; ar = 5'($urandom_range(0, 31)); ad = $urandom;
      end
      if (!mp && $urandom_range(0, 2) != 0) begin
        mp = 1; mr = 5'($urandom_range(0, 31)); md = $urandom;
      end
      av = ap; mv = mp;
      hold = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 39) == 0);
      cycle();
      if (s_ar) ap = 0;
      if (s_mr) mp = 0;
    end
    idle_in();
    for (int c = 0; c < 6; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
